// File: rtl/tournament_chooser_if.sv
// Lookup / update / clear bundle between fetch-EX logic and the tournament chooser table.
// The chooser itself connects through the slave modport.
interface tournament_chooser_if #(
  parameter int CNT_W  = 2,
  parameter int HIST_W = 8
);
  logic              lk_valid;
  logic [31:0]       lk_pc;
  logic [HIST_W-1:0] lk_ghr;
  logic              sel_valid;
  logic              sel_global;
  logic [CNT_W-1:0]  sel_counter;
  logic              up_valid;
  logic [31:0]       up_pc;
  logic [HIST_W-1:0] up_ghr;
  logic              up_local_ok;
  logic              up_global_ok;
  logic              clear;
  logic              ready;

  modport master (
    output lk_valid, lk_pc, lk_ghr,
    output up_valid, up_pc, up_ghr, up_local_ok, up_global_ok, clear,
    input  sel_valid, sel_global, sel_counter, ready
  );

  modport slave (
    input  lk_valid, lk_pc, lk_ghr,
    input  up_valid, up_pc, up_ghr, up_local_ok, up_global_ok, clear,
    output sel_valid, sel_global, sel_counter, ready
  );
endinterface

// File: rtl/tournament_chooser.sv
// Per-branch saturating chooser table for the tournament predictor: picks local vs global
// component, trained on resolution, with a walking full-table clear gated by ready.
module tournament_chooser #(
  parameter int CNT_W      = 2,
  parameter int ENTRIES    = 64,
  parameter int HIST_W     = 8,
  parameter int INDEX_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tournament_chooser_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] INIT    = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(ENTRIES - 1);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] tbl_q [ENTRIES];
  logic [CNT_W-1:0] tbl_d [ENTRIES];
  logic             sel_valid_q, sel_valid_d;
  logic [CNT_W-1:0] sel_counter_q, sel_counter_d;

  logic [IDX_W+HIST_W-1:0] lk_hist_ext, up_hist_ext;
  logic [IDX_W-1:0]        lk_idx, up_idx;
  logic                    run, lk_en, upd_en;
  logic [CNT_W-1:0]        up_cur, up_new;
  logic                    unused_bits;

  // History is zero-extended then truncated so any HIST_W/IDX_W ratio folds the same way.
  assign lk_hist_ext = {{IDX_W{1'b0}}, bus.lk_ghr};
  assign up_hist_ext = {{IDX_W{1'b0}}, bus.up_ghr};
  assign lk_idx = bus.lk_pc[IDX_W+1:2] ^ ((INDEX_MODE == 1) ? lk_hist_ext[IDX_W-1:0] : '0);
  assign up_idx = bus.up_pc[IDX_W+1:2] ^ ((INDEX_MODE == 1) ? up_hist_ext[IDX_W-1:0] : '0);
  assign unused_bits = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0],
                         bus.up_pc[31:IDX_W+2], bus.up_pc[1:0], lk_hist_ext, up_hist_ext};

  assign run    = (state_q == RUN);
  assign lk_en  = run && bus.lk_valid;
  // An update arriving with the clear pulse is dropped: the table is about to be wiped.
  assign upd_en = run && bus.up_valid && !bus.clear;

  always_comb begin
    up_cur = tbl_q[up_idx];
    up_new = up_cur;
    if (bus.up_global_ok && !bus.up_local_ok && up_cur != CNT_MAX) begin
      up_new = up_cur + 1'b1;
    end else if (bus.up_local_ok && !bus.up_global_ok && up_cur != '0) begin
      up_new = up_cur - 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      tbl_d[i] = tbl_q[i];
      if (!run && ptr_q == IDX_W'(i)) begin
        tbl_d[i] = INIT;
      end else if (upd_en && up_idx == IDX_W'(i)) begin
        tbl_d[i] = up_new;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RUN: begin
        if (bus.clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Same-index update bypasses into the lookup so fetch sees the post-update counter.
  always_comb begin
    sel_valid_d   = lk_en;
    sel_counter_d = sel_counter_q;
    if (lk_en) begin
      sel_counter_d = (upd_en && up_idx == lk_idx) ? up_new : tbl_q[lk_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      ptr_q         <= '0;
      sel_valid_q   <= 1'b0;
      sel_counter_q <= '0;
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= INIT;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      sel_valid_q   <= sel_valid_d;
      sel_counter_q <= sel_counter_d;
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= tbl_d[i];
    end
  end

  assign bus.sel_valid   = sel_valid_q;
  assign bus.sel_counter = sel_counter_q;
  assign bus.sel_global  = sel_counter_q[CNT_W-1];
  assign bus.ready       = run;
endmodule

// File: tb/tb_tournament_chooser.sv
// Drives a PC-indexed and a PC^GHR-indexed chooser with identical stimulus and checks
// both against a table-level reference model every cycle, plus directed literal checks.
module tb_tournament_chooser;
  logic        clk;
  logic        rst_n;
  logic        lk_valid, up_valid, up_local_ok, up_global_ok, clear;
  logic [31:0] lk_pc, up_pc;
  logic [7:0]  lk_ghr, up_ghr;

  int n_checks = 0;
  int n_errors = 0;

  tournament_chooser_if #(.CNT_W(2), .HIST_W(8)) if0 ();
  tournament_chooser_if #(.CNT_W(2), .HIST_W(8)) if1 ();

  assign if0.lk_valid = lk_valid;      assign if1.lk_valid = lk_valid;
  assign if0.lk_pc = lk_pc;            assign if1.lk_pc = lk_pc;
  assign if0.lk_ghr = lk_ghr;          assign if1.lk_ghr = lk_ghr;
  assign if0.up_valid = up_valid;      assign if1.up_valid = up_valid;
  assign if0.up_pc = up_pc;            assign if1.up_pc = up_pc;
  assign if0.up_ghr = up_ghr;          assign if1.up_ghr = up_ghr;
  assign if0.up_local_ok = up_local_ok;   assign if1.up_local_ok = up_local_ok;
  assign if0.up_global_ok = up_global_ok; assign if1.up_global_ok = up_global_ok;
  assign if0.clear = clear;            assign if1.clear = clear;

  tournament_chooser #(.CNT_W(2), .ENTRIES(64), .HIST_W(8), .INDEX_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  tournament_chooser #(.CNT_W(2), .ENTRIES(64), .HIST_W(8), .INDEX_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one counter array per DUT, clear modelled as a 64-cycle busy window.
  int tbl [2][64];
  bit m_clr [2];
  int m_left [2];
  bit exp_sv [2];
  int exp_cnt [2];

  function automatic void chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic int midx(int d, logic [31:0] pc, logic [7:0] g);
    int i;
    i = int'((pc >> 2) & 32'h3F);
    if (d == 1) i = i ^ int'(g & 8'h3F);
    return i;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int e = 0; e < 64; e++) tbl[d][e] = 1;
      m_clr[d] = 0; m_left[d] = 0; exp_sv[d] = 0; exp_cnt[d] = 0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      int li, ui;
      li = midx(d, lk_pc, lk_ghr);
      ui = midx(d, up_pc, up_ghr);
      if (m_clr[d]) begin
        exp_sv[d] = 0;
        m_left[d]--;
        if (m_left[d] == 0) m_clr[d] = 0;
      end else if (clear) begin
        exp_sv[d] = lk_valid;
        if (lk_valid) exp_cnt[d] = tbl[d][li];
        for (int e = 0; e < 64; e++) tbl[d][e] = 1;
        m_clr[d] = 1;
        m_left[d] = 64;
      end else begin
        if (up_valid) begin
          if (up_global_ok && !up_local_ok && tbl[d][ui] < 3) tbl[d][ui]++;
          else if (up_local_ok && !up_global_ok && tbl[d][ui] > 0) tbl[d][ui]--;
        end
        exp_sv[d] = lk_valid;
        if (lk_valid) exp_cnt[d] = tbl[d][li];
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready0", int'(if0.ready), int'(!m_clr[0]));
      chk("sel_valid0", int'(if0.sel_valid), int'(exp_sv[0]));
      chk("sel_counter0", int'(if0.sel_counter), exp_cnt[0]);
      chk("sel_global0", int'(if0.sel_global), int'(exp_cnt[0] >= 2));
      chk("ready1", int'(if1.ready), int'(!m_clr[1]));
      chk("sel_valid1", int'(if1.sel_valid), int'(exp_sv[1]));
      chk("sel_counter1", int'(if1.sel_counter), exp_cnt[1]);
      chk("sel_global1", int'(if1.sel_global), int'(exp_cnt[1] >= 2));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step(bit lk, logic [31:0] lpc, logic [7:0] lg, bit up, logic [31:0] upc,
                      logic [7:0] ug, bit lok, bit gok, bit clr);
    lk_valid = lk; lk_pc = lpc; lk_ghr = lg;
    up_valid = up; up_pc = upc; up_ghr = ug;
    up_local_ok = lok; up_global_ok = gok; clear = clr;
    cyc();
  endtask

  task automatic rand_step(int clr_odds);
    logic [31:0] lpc, upc;
    logic [7:0]  lg, ug;
    lpc = ($urandom_range(0, 1) == 1) ? $urandom : (32'h100 + ($urandom_range(0, 7) << 2));
    lg  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
    if ($urandom_range(0, 3) == 0) begin
      upc = lpc; ug = lg;
    end else begin
      upc = ($urandom_range(0, 1) == 1) ? $urandom : (32'h100 + ($urandom_range(0, 7) << 2));
      ug  = 8'($urandom_range(0, 3));
    end
    step(1'($urandom), lpc, lg, 1'($urandom), upc, ug, 1'($urandom), 1'($urandom),
         $urandom_range(0, clr_odds) == 0);
  endtask

  task automatic train_and_clear(output int busy);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 32'(i * 4), 0, 0, 1, 0);
      step(0, 0, 0, 1, 32'(i * 4), 0, 0, 1, 0);
    end
    step(1, 0, 0, 1, 32'h4, 0, 1, 0, 1);
    busy = 0;
  endtask

  initial begin
    int exp_inc [3];
    int exp_dec [4];
    int busy;
    exp_inc = '{2, 3, 3};
    exp_dec = '{2, 1, 0, 0};
    rst_n = 1'b0;
    lk_valid = 0; up_valid = 0; up_local_ok = 0; up_global_ok = 0; clear = 0;
    lk_pc = 0; up_pc = 0; lk_ghr = 0; up_ghr = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", int'(if0.ready), 1);
    chk("reset_sel_valid", int'(if0.sel_valid), 0);
    chk("reset_sel_counter", int'(if0.sel_counter), 0);
    chk("reset_sel_global", int'(if0.sel_global), 0);

    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("first_lookup_valid", int'(if0.sel_valid), 1);
    chk("first_lookup_cnt", int'(if0.sel_counter), 1);
    chk("first_lookup_global", int'(if0.sel_global), 0);

    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 32'h100, 0, 0, 1, 0);
      step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      chk("inc_cnt", int'(if0.sel_counter), exp_inc[k]);
      chk("inc_global", int'(if0.sel_global), 1);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 32'h100, 0, 1, 0, 0);
      step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      chk("dec_cnt", int'(if0.sel_counter), exp_dec[k]);
    end
    step(0, 0, 0, 1, 32'h100, 0, 1, 1, 0);
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    chk("both_ok_hold", int'(if0.sel_counter), 0);

    step(1, 32'h104, 0, 1, 32'h104, 0, 0, 1, 0);
    chk("bypass_same_idx", int'(if0.sel_counter), 2);
    step(1, 32'h108, 0, 1, 32'h104, 0, 0, 1, 0);
    chk("bypass_other_idx", int'(if0.sel_counter), 1);

    step(0, 0, 0, 1, 32'h100, 8'h05, 0, 1, 0);
    step(1, 32'h114, 8'h00, 0, 0, 0, 0, 0, 0);
    chk("xor_idx_hit_m1", int'(if1.sel_counter), 2);
    chk("xor_idx_pc_m0", int'(if0.sel_counter), 1);
    step(1, 32'h100, 8'h00, 0, 0, 0, 0, 0, 0);
    chk("xor_idx_pc_m1", int'(if1.sel_counter), 0);

    repeat (3000) rand_step(300);
    while (m_clr[0]) step(0, 0, 0, 0, 0, 0, 0, 0, 0);

    train_and_clear(busy);
    while (!if0.ready && busy < 200) begin
      rand_step(4);
      busy++;
    end
    chk("clear_busy_cycles", busy, 64);
    for (int i = 0; i < 64; i++) begin
      step(1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
      chk("after_clear_cnt", int'(if0.sel_counter), 1);
    end

    train_and_clear(busy);
    repeat (19) rand_step(4);
    chk("clear_in_progress", int'(if0.ready), 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_clear_ready0", int'(if0.ready), 1);
    chk("rst_mid_clear_ready1", int'(if1.ready), 1);
    chk("rst_mid_clear_sel_valid", int'(if0.sel_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      step(1, 32'(i * 4), 0, 0, 0, 0, 0, 0, 0);
      chk("after_rst_cnt", int'(if0.sel_counter), 1);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
